// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB->ID write-through bypass and load-use bubble insertion.
// Optional stall counter enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        idRs,
    input  logic [4:0]        idRt,
    input  logic [4:0]        idRd,
    input  logic [DATA_W-1:0] idReadData1,
    input  logic [DATA_W-1:0] idReadData2,
    input  logic [15:0]       idImm,
    input  logic [CTRL_W-1:0] idCtrl,
    input  logic              idRegWrite,
    input  logic              idMemRead,
    input  logic              idRegDst,
    input  logic              idUsesRt,
    input  logic              wbRegWrite,
    input  logic [4:0]        wbWriteReg,
    input  logic [DATA_W-1:0] wbWriteData,
    input  logic              hold,
    input  logic              flush,
    output logic [4:0]        exRs,
    output logic [4:0]        exRt,
    output logic [4:0]        exWriteReg,
    output logic [DATA_W-1:0] exA,
    output logic [DATA_W-1:0] exB,
    output logic [DATA_W-1:0] exImm,
    output logic [CTRL_W-1:0] exCtrl,
    output logic              exRegWrite,
    output logic              exMemRead,
    output logic              exValid,
    output logic              stall,
    output logic [31:0]       stallCount
);

    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic              hazard;
    logic              wbHit;

    // The register file writes on the same edge we capture, so forward WB data here.
    always_comb begin
        opA = idReadData1;
        if (idRs == 5'd0)
            opA = '0;
        else if (wbRegWrite && wbWriteReg == idRs)
            opA = wbWriteData;

        opB = idReadData2;
        if (idRt == 5'd0)
            opB = '0;
        else if (wbRegWrite && wbWriteReg == idRt)
            opB = wbWriteData;
    end

    assign hazard = exValid && exMemRead && (exWriteReg != 5'd0) &&
                    ((exWriteReg == idRs) || (idUsesRt && exWriteReg == idRt));
    assign stall  = hazard && !flush && !hold;
    assign wbHit  = wbRegWrite && (wbWriteReg != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exRs       <= '0;
            exRt       <= '0;
            exWriteReg <= '0;
            exA        <= '0;
            exB        <= '0;
            exImm      <= '0;
            exCtrl     <= '0;
            exRegWrite <= 1'b0;
            exMemRead  <= 1'b0;
            exValid    <= 1'b0;
        end else if (hold) begin
            // Keep held operands coherent with writes retiring while frozen.
            if (wbHit && wbWriteReg == exRs)
                exA <= wbWriteData;
            if (wbHit && wbWriteReg == exRt)
                exB <= wbWriteData;
        end else if (flush || hazard) begin
            exRs       <= '0;
            exRt       <= '0;
            exWriteReg <= '0;
            exA        <= '0;
            exB        <= '0;
            exImm      <= '0;
            exCtrl     <= '0;
            exRegWrite <= 1'b0;
            exMemRead  <= 1'b0;
            exValid    <= 1'b0;
        end else begin
            exRs       <= idRs;
            exRt       <= idRt;
            exWriteReg <= idRegDst ? idRd : idRt;
            exA        <= opA;
            exB        <= opB;
            exImm      <= {{(DATA_W-16){idImm[15]}}, idImm};
            exCtrl     <= idCtrl;
            exRegWrite <= idRegWrite;
            exMemRead  <= idMemRead;
            exValid    <= 1'b1;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stallCountReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stallCountReg <= '0;
        else if (stall && stallCountReg != 32'hFFFF_FFFF)
            stallCountReg <= stallCountReg + 32'd1;
    end

    assign stallCount = stallCountReg;
`else
    assign stallCount = 32'd0;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the pipelined CPU, directly downstream of the register file.
- Captures the two register-file read operands, the sign-extended immediate and the decoded control for the instruction in ID, and presents them to EX.
- Performs WB->ID write-through bypass, because the register file writes on the clock edge but is read combinationally in the same cycle.
- Detects load-use hazards, inserts a bubble and drives the stall request to PC and IF/ID.

Parameters:
- DATA_W, 32, operand and immediate width.
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle carried through.

Ports:
- clk  input  1  stage clock; all state updates on the rising edge.
- reset  input  1  asynchronous reset, active-low: state clears while reset==0.
- idRs, idRt, idRd  input  5 each  register specifiers of the ID instruction.
- idReadData1, idReadData2  input  DATA_W each  register-file read data for idRs and idRt.
- idImm  input  16  raw immediate.
- idCtrl  input  CTRL_W  control bundle.
- idRegWrite, idMemRead, idRegDst, idUsesRt  input  1 each  decoded control bits.
- wbRegWrite  input  1  WB write enable, same signal that drives the register file.
- wbWriteReg  input  5  WB destination register.
- wbWriteData  input  DATA_W  WB write data.
- hold  input  1  freeze request from downstream.
- flush  input  1  kill the ID instruction, e.g. on a taken branch.
- exRs, exRt, exWriteReg  output  5 each.
- exA, exB, exImm  output  DATA_W each.
- exCtrl  output  CTRL_W.
- exRegWrite, exMemRead, exValid  output  1 each.
- stall  output  1  combinational; stalls PC and IF/ID.
- stallCount  output  32  see Optional Feature.

Behaviour:
- Reset: while reset==0, every registered output is 0 (exA/exB/exImm/exCtrl/spec fields/valid/regWrite/memRead); stallCount is 0. Reset wins over every other input.
- Operand selection, effective value opA (opB is the same with idRt/idReadData2):
  - opA = 0 if idRs==0.
  - Else opA = wbWriteData if wbRegWrite && wbWriteReg==idRs.
  - Else opA = idReadData1.
- Immediate: exImm = idImm sign-extended to DATA_W.
- Destination select: exWriteReg = idRegDst ? idRd : idRt.
- Hazard condition: hazard = exValid && exMemRead && exWriteReg!=0 && (exWriteReg==idRs || (idUsesRt && exWriteReg==idRt)).
- Stall output: stall = hazard && !flush && !hold.
- Per-edge priority (reset aside):
  1. hold: all registers keep their value. Exception: if wbRegWrite && wbWriteReg!=0, then exA is refreshed from wbWriteData when wbWriteReg==exRs, and exB when wbWriteReg==exRt. Held operands therefore never go stale.
  2. flush: bubble.
  3. hazard: bubble. The ID instruction is re-presented next cycle by the stalled IF/ID.
  4. Otherwise: load all ex* fields from the ID inputs and the operand selection; exValid=1.
- Bubble: exValid=0, exRegWrite=0, exMemRead=0, exCtrl=0. Other fields are don't-care, but are cleared to 0 for verification.
- Latency: one cycle, ID to EX.
- Load-use stall lasts exactly one cycle: the bubble clears exMemRead, so hazard drops on the next cycle.
- Reset asserted mid-stall: stall drops immediately (exValid=0); no residual state remains.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- Defined: stallCount increments by 1 on each edge where a hazard bubble is inserted (case 3 only; flush and hold do not count). It saturates at 32'hFFFFFFFF and clears on reset.
- Undefined: stallCount is constant 0 and no counter logic is synthesised.

Test Plan:
- Plain load: idRs=5, idReadData1=32'h1234, idImm=16'h8000, no hazard -> next cycle exA=32'h1234, exImm=32'hFFFF8000, exValid=1.
- WB bypass: idRs=3, idReadData1=0, wbRegWrite=1, wbWriteReg=3, wbWriteData=32'hDEAD -> exA=32'hDEAD.
- $0 rule: idRs=0, wbWriteReg=0, wbWriteData=7 -> exA=0.
- Load-use: EX holds lw (exMemRead=1, exWriteReg=8); ID has idRs=8 -> stall=1 for exactly one cycle, bubble in EX (exValid=0). The following cycle loads the instruction and stallCount=1 with the macro defined.
- Flush during hazard: same as the load-use case but with flush=1 -> stall=0, bubble inserted, stallCount unchanged.
- Hold with WB write: hold=1, exRs=4, wbRegWrite=1, wbWriteReg=4, wbWriteData=9 -> exA=9, all other fields unchanged. Then assert reset=0 mid-hold -> all outputs 0 immediately, asynchronously.
